dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port data memory (word RAM with combinational read, write on posedge `clk`, byte-enable write merge). It shares the RAM between the pipeline MEM stage (CPU port) and a DMA/debug loader (DMA port). It grants at most one access per cycle, using round-robin with an optional bounded lock for read-modify-write sequences. It also rejects illegal byte-enable codes and returns registered read data with a one-cycle acknowledge.

---
 rtl/dmem_arbiter_if.sv | 25 ++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter.
//   master : requester side (pipeline MEM stage or DMA/debug loader)
//            drives req/we/lock/adr/be/din, receives gnt/ack/err/rdata
//   slave  : arbiter side
//   N      : word address width, M : data width
interface dmem_arbiter_if #(
    parameter int N = 8,
    parameter int M = 32
);
    logic         req;
    logic         we;
    logic         lock;
    logic [N-1:0] adr;
    logic [3:0]   be;
    logic [M-1:0] din;
    logic         gnt;
    logic         ack;
    logic         err;
    logic [M-1:0] rdata;

    modport master (output req, we, lock, adr, be, din,
                    input  gnt, ack, err, rdata);
    modport slave  (input  req, we, lock, adr, be, din,
                    output gnt, ack, err, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the CPU port (c)
// and the DMA/debug port (d). At most one access is granted per cycle,
// round-robin on ties, with an optional bounded lock that keeps one port
// as owner for read-modify-write sequences.
//   clk, clrn     : clock, asynchronous active-low reset
//   c, d          : requester ports (dmem_arbiter_if.slave)
//   m_we/adr/be/din : RAM drive, m_dout : RAM combinational read data
module dmem_arbiter #(
    parameter int N    = 8,
    parameter int M    = 32,
    parameter int LMAX = 16
) (
    input  logic         clk,
    input  logic         clrn,
    dmem_arbiter_if.slave c,
    dmem_arbiter_if.slave d,
    output logic         m_we,
    output logic [N-1:0] m_adr,
    output logic [3:0]   m_be,
    output logic [M-1:0] m_din,
    input  logic [M-1:0] m_dout
);
    typedef enum logic [1:0] {IDLE, LOCK_C, LOCK_D} st_t;

    localparam logic       PTR_C = 1'b0;
    localparam logic       PTR_D = 1'b1;
    localparam logic [7:0] LMAX8 = 8'(LMAX);

    function automatic logic be_ok(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
            default:                   be_ok = 1'b0;
        endcase
    endfunction

    st_t          st;
    logic         last;
    logic [7:0]   cnt;
    logic [7:0]   cnt_inc;
    logic         c_gnt, d_gnt;
    logic         c_ok, d_ok;
    logic         c_ack_q, d_ack_q;
    logic         c_err_q, d_err_q;
    logic [M-1:0] c_rd_q, d_rd_q;

    // Grant is combinational so there is no request-to-grant bubble.
    // In IDLE a tie goes to the port that was not served last.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        case (st)
            LOCK_C:  c_gnt = c.req;
            LOCK_D:  d_gnt = d.req;
            default: begin
                c_gnt = c.req & (~d.req | (last == PTR_D));
                d_gnt = d.req & (~c.req | (last == PTR_C));
            end
        endcase
    end

    assign c_ok    = be_ok(c.be);
    assign d_ok    = be_ok(d.be);
    assign cnt_inc = cnt + 8'd1;

    // Without a grant the RAM bus rests on the CPU port.
    assign m_adr = d_gnt ? d.adr : c.adr;
    assign m_be  = d_gnt ? d.be  : c.be;
    assign m_din = d_gnt ? d.din : c.din;
    assign m_we  = (c_gnt & c.we & c_ok) | (d_gnt & d.we & d_ok);

    // cnt counts ownership cycles including the entry cycle, so the
    // lock is forced off on the cycle that would make LMAX.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            st   <= IDLE;
            last <= PTR_D;
            cnt  <= 8'd0;
        end else begin
            case (st)
                IDLE: begin
                    if (c_gnt) begin
                        last <= PTR_C;
                        if (c.lock) begin
                            st  <= LOCK_C;
                            cnt <= 8'd1;
                        end
                    end else if (d_gnt) begin
                        last <= PTR_D;
                        if (d.lock) begin
                            st  <= LOCK_D;
                            cnt <= 8'd1;
                        end
                    end
                end
                LOCK_C: begin
                    cnt <= cnt_inc;
                    if (!c.lock || cnt_inc == LMAX8) begin
                        st   <= IDLE;
                        last <= PTR_C;
                    end
                end
                LOCK_D: begin
                    cnt <= cnt_inc;
                    if (!d.lock || cnt_inc == LMAX8) begin
                        st   <= IDLE;
                        last <= PTR_D;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // m_dout is already steered to the granted port's address, so a
    // granted read captures it at the edge ending the grant cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            c_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            c_err_q <= 1'b0;
            d_err_q <= 1'b0;
            c_rd_q  <= '0;
            d_rd_q  <= '0;
        end else begin
            c_ack_q <= c_gnt;
            d_ack_q <= d_gnt;
            c_err_q <= c_gnt & c.we & ~c_ok;
            d_err_q <= d_gnt & d.we & ~d_ok;
            if (c_gnt && !c.we) c_rd_q <= m_dout;
            if (d_gnt && !d.we) d_rd_q <= m_dout;
        end
    end

    assign c.gnt   = c_gnt;
    assign d.gnt   = d_gnt;
    assign c.ack   = c_ack_q;
    assign d.ack   = d_ack_q;
    assign c.err   = c_err_q;
    assign d.err   = d_err_q;
    assign c.rdata = c_rd_q;
    assign d.rdata = d_rd_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with hand-computed expectations.
// Grants are checked each cycle; each expected grant queues its expected
// ack (cycle, err, read data) and a monitor pops on every ack.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        clrn;
    logic        m_we;
    logic [7:0]  m_adr;
    logic [3:0]  m_be;
    logic [31:0] m_din;
    logic [31:0] m_dout;

    dmem_arbiter_if #(.N(8), .M(32)) cif ();
    dmem_arbiter_if #(.N(8), .M(32)) dif ();

    dmem_arbiter #(.N(8), .M(32), .LMAX(16)) dut (
        .clk(clk), .clrn(clrn), .c(cif), .d(dif),
        .m_we(m_we), .m_adr(m_adr), .m_be(m_be), .m_din(m_din), .m_dout(m_dout)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, low-lane write data placed by BE.
    logic [31:0] ram [0:255];
    bit          ram_ready;
    assign m_dout = ram[m_adr];
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= {4{8'(i)}};
            ram_ready <= 1'b1;
        end else if (m_we) begin
            case (m_be)
                4'b0001: ram[m_adr][7:0]   <= m_din[7:0];
                4'b0010: ram[m_adr][15:8]  <= m_din[7:0];
                4'b0100: ram[m_adr][23:16] <= m_din[7:0];
                4'b1000: ram[m_adr][31:24] <= m_din[7:0];
                4'b0011: ram[m_adr][15:0]  <= m_din[15:0];
                4'b1100: ram[m_adr][31:16] <= m_din[15:0];
                4'b1111: ram[m_adr]        <= m_din;
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        rd;
        logic        err;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t cq[$];
    exp_t dq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setc(input logic req, we, lock, input logic [7:0] adr,
                        input logic [3:0] be, input logic [31:0] din);
        cif.req = req; cif.we = we; cif.lock = lock;
        cif.adr = adr; cif.be = be; cif.din = din;
    endtask

    task automatic setd(input logic req, we, lock, input logic [7:0] adr,
                        input logic [3:0] be, input logic [31:0] din);
        dif.req = req; dif.we = we; dif.lock = lock;
        dif.adr = adr; dif.be = be; dif.din = din;
    endtask

    // One cycle: check grants/m_we mid-cycle, queue the expected acks.
    task automatic step(input logic ecg, input logic edg, input logic emwe,
                        input logic [31:0] cdat, input logic [31:0] ddat,
                        input logic cerr = 1'b0, input logic derr = 1'b0);
        @(negedge clk);
        chk("c_gnt", {31'b0, cif.gnt}, {31'b0, ecg});
        chk("d_gnt", {31'b0, dif.gnt}, {31'b0, edg});
        chk("m_we",  {31'b0, m_we},    {31'b0, emwe});
        if (ecg) cq.push_back('{rd: !cif.we, err: cerr, dat: cdat, cyc: cyc + 1});
        if (edg) dq.push_back('{rd: !dif.we, err: derr, dat: ddat, cyc: cyc + 1});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (clrn) begin
            if (cif.ack) begin
                if (cq.size() == 0) chk("c_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = cq.pop_front();
                    chk("c_ack_cycle", cyc, e.cyc);
                    chk("c_err", {31'b0, cif.err}, {31'b0, e.err});
                    if (e.rd) chk("c_rdata", cif.rdata, e.dat);
                end
            end
            if (dif.ack) begin
                if (dq.size() == 0) chk("d_ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = dq.pop_front();
                    chk("d_ack_cycle", cyc, e.cyc);
                    chk("d_err", {31'b0, dif.err}, {31'b0, e.err});
                    if (e.rd) chk("d_rdata", dif.rdata, e.dat);
                end
            end
        end
    end

    initial begin
        clrn = 1'b0;
        setc(0, 0, 0, 8'h00, 4'hF, 32'h0);
        setd(0, 0, 0, 8'h00, 4'hF, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_c_ack",   {31'b0, cif.ack}, 32'd0);
        chk("rst_d_ack",   {31'b0, dif.ack}, 32'd0);
        chk("rst_c_rdata", cif.rdata, 32'd0);
        chk("rst_d_rdata", dif.rdata, 32'd0);
        chk("rst_m_we",    {31'b0, m_we}, 32'd0);
        @(posedge clk);
        #1 clrn = 1'b1;

        // Alternating reads: C, D, C, D.
        setc(1, 0, 0, 8'h01, 4'hF, 32'h0);
        setd(1, 0, 0, 8'h02, 4'hF, 32'h0);
        step(1, 0, 0, 32'h01010101, 32'h0);
        step(0, 1, 0, 32'h0, 32'h02020202);
        step(1, 0, 0, 32'h01010101, 32'h0);
        step(0, 1, 0, 32'h0, 32'h02020202);
        setc(0, 0, 0, 8'h00, 4'hF, 32'h0);
        setd(0, 0, 0, 8'h00, 4'hF, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0);

        // Full write, byte-1 merge, read back.
        setc(1, 1, 0, 8'h05, 4'b1111, 32'hAABBCCDD);
        step(1, 0, 1, 32'h0, 32'h0);
        setc(1, 1, 0, 8'h05, 4'b0010, 32'h000000EE);
        step(1, 0, 1, 32'h0, 32'h0);
        setc(1, 0, 0, 8'h05, 4'hF, 32'h0);
        step(1, 0, 0, 32'hAABBEEDD, 32'h0);
        setc(0, 0, 0, 8'h00, 4'hF, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0);

        // Illegal BE on DMA write: granted, no RAM write, err with ack.
        setd(1, 1, 0, 8'h07, 4'b0101, 32'hFFFFFFFF);
        step(0, 1, 0, 32'h0, 32'h0, 1'b0, 1'b1);
        setd(1, 0, 0, 8'h07, 4'hF, 32'h0);
        step(0, 1, 0, 32'h0, 32'h07070707);

        // Lock bound: CPU owns 16 cycles, DMA gets cycle 17.
        setc(1, 0, 1, 8'h01, 4'hF, 32'h0);
        setd(1, 0, 0, 8'h02, 4'hF, 32'h0);
        repeat (16) step(1, 0, 0, 32'h01010101, 32'h0);
        step(0, 1, 0, 32'h0, 32'h02020202);
        setc(0, 0, 0, 8'h00, 4'hF, 32'h0);
        setd(0, 0, 0, 8'h00, 4'hF, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0);

        // Early release: lock dropped on 3rd ownership cycle.
        setc(1, 0, 1, 8'h01, 4'hF, 32'h0);
        setd(1, 0, 0, 8'h02, 4'hF, 32'h0);
        step(1, 0, 0, 32'h01010101, 32'h0);
        step(1, 0, 0, 32'h01010101, 32'h0);
        setc(1, 0, 0, 8'h01, 4'hF, 32'h0);
        step(1, 0, 0, 32'h01010101, 32'h0);
        step(0, 1, 0, 32'h0, 32'h02020202);
        setc(0, 0, 0, 8'h00, 4'hF, 32'h0);
        setd(0, 0, 0, 8'h00, 4'hF, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0);

        // Reset during LOCK_D with a read granted.
        setd(1, 0, 1, 8'h02, 4'hF, 32'h0);
        step(0, 1, 0, 32'h0, 32'h02020202);
        setc(1, 0, 0, 8'h01, 4'hF, 32'h0);
        setd(1, 0, 1, 8'h07, 4'hF, 32'h0);
        @(negedge clk);
        chk("lockd_c_gnt", {31'b0, cif.gnt}, 32'd0);
        chk("lockd_d_gnt", {31'b0, dif.gnt}, 32'd1);
        #1 clrn = 1'b0;
        @(posedge clk);
        #1 clrn = 1'b1;
        chk("post_rst_c_ack",   {31'b0, cif.ack}, 32'd0);
        chk("post_rst_d_ack",   {31'b0, dif.ack}, 32'd0);
        chk("post_rst_c_rdata", cif.rdata, 32'd0);
        chk("post_rst_d_rdata", dif.rdata, 32'd0);
        setc(1, 0, 0, 8'h01, 4'hF, 32'h0);
        setd(1, 0, 0, 8'h02, 4'hF, 32'h0);
        step(1, 0, 0, 32'h01010101, 32'h0);
        setc(0, 0, 0, 8'h00, 4'hF, 32'h0);
        setd(0, 0, 0, 8'h00, 4'hF, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0);

        chk("c_acks_missing", cq.size(), 32'd0);
        chk("d_acks_missing", dq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
